// File: rtl/uart_boot_loader.sv
// UART program loader: receives a framed image, writes it into the 256x16 program RAM, then restarts the CPU.
// Optional trailer checksum byte is enabled by defining UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          ADDR_W       = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    output logic              cpu_halt,
    output logic              cpu_restart,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int REM_W = ADDR_W + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, DONE, ERR} state_t;
`endif

    // ---------------- RX synchroniser and byte engine ----------------
    logic             rx_s1, rx_sync, rx_prev;
    rx_state_t        r_state, r_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             bit_tick, half_tick, byte_valid, frame_err;

    assign bit_tick   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick  = (r_cnt == CNT_W'(HALF - 1));
    assign byte_valid = (r_state == R_STOP) && bit_tick && rx_sync;
    assign frame_err  = (r_state == R_STOP) && bit_tick && !rx_sync;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_prev && !rx_sync) r_next = R_START;
            R_START: if (half_tick) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && r_bit == 3'd7) r_next = R_STOP;
            R_STOP:  if (bit_tick) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
            r_state <= r_next;
            // Counter restarts on every state change and on each data-bit sample
            if (r_state == R_IDLE || r_next != r_state || (r_state == R_DATA && bit_tick))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == R_START)
                r_bit <= '0;
            if (r_state == R_DATA && bit_tick) begin
                r_shift <= {rx_sync, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    // ---------------- Session FSM ----------------
    state_t           state, s_next;
    logic [7:0]       len_hi, dat_hi;
    logic [REM_W-1:0] remaining;
    logic             wr_pend;
    logic [15:0]      len_word;
    logic             len_bad, is_sync, err_load;
    logic [1:0]       err_val;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]       chk;
`endif

    assign len_word = {len_hi, r_shift};
    assign len_bad  = (len_word == 16'd0) || ({1'b0, len_word} > (17'd1 << ADDR_W));
    assign is_sync  = byte_valid && (r_shift == SYNC_BYTE);

    always_comb begin
        s_next   = state;
        err_load = 1'b0;
        err_val  = 2'd0;
        if (state != IDLE && state != DONE && state != ERR && frame_err) begin
            s_next   = ERR;
            err_load = 1'b1;
            err_val  = 2'd1;
        end else begin
            case (state)
                IDLE:   if (is_sync) s_next = LEN_HI;
                LEN_HI: if (byte_valid) s_next = LEN_LO;
                LEN_LO: if (byte_valid) begin
                    if (len_bad) begin
                        s_next   = ERR;
                        err_load = 1'b1;
                        err_val  = 2'd2;
                    end else begin
                        s_next = DAT_HI;
                    end
                end
                DAT_HI: if (byte_valid) s_next = DAT_LO;
                // The write happens one cycle after the low byte, still inside DAT_LO
                DAT_LO: if (wr_pend) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    s_next = (remaining == REM_W'(1)) ? CHK : DAT_HI;
`else
                    s_next = (remaining == REM_W'(1)) ? DONE : DAT_HI;
`endif
                end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                CHK: if (byte_valid) begin
                    if (r_shift == chk) begin
                        s_next = DONE;
                    end else begin
                        s_next   = ERR;
                        err_load = 1'b1;
                        err_val  = 2'd3;
                    end
                end
`endif
                DONE:    s_next = IDLE;
                ERR:     if (is_sync) s_next = LEN_HI;
                default: s_next = IDLE;
            endcase
        end
    end

    assign ram_we      = (state == DAT_LO) && wr_pend;
    assign cpu_halt    = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign cpu_restart = (state == DONE);
    assign err         = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_hi    <= '0;
            dat_hi    <= '0;
            remaining <= '0;
            wr_pend   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            err_code  <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            state <= s_next;
            if (err_load)
                err_code <= err_val;
            else if ((state == IDLE || state == ERR) && is_sync)
                err_code <= 2'd0;
            case (state)
                LEN_HI: if (byte_valid) len_hi <= r_shift;
                LEN_LO: if (byte_valid && !len_bad) begin
                    remaining <= REM_W'(len_word);
                    ram_addr  <= '0;
                end
                DAT_HI: if (byte_valid) dat_hi <= r_shift;
                DAT_LO: begin
                    if (byte_valid) begin
                        ram_wdata <= {dat_hi, r_shift};
                        wr_pend   <= 1'b1;
                    end
                    if (wr_pend) begin
                        wr_pend   <= 1'b0;
                        ram_addr  <= ram_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            // Checksum covers the length and data bytes only
            if ((state == IDLE || state == ERR) && is_sync)
                chk <= '0;
            else if (byte_valid && (state == LEN_HI || state == LEN_LO ||
                                    state == DAT_HI || state == DAT_LO))
                chk <= chk ^ r_shift;
`endif
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader; define UART_BOOT_LOADER_CHECKSUM_EN to also cover the checksum trailer.
module tb_uart_boot_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 8;
    localparam int WR_W   = ADDR_W + 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_we, cpu_halt, cpu_restart, done, err;
    logic [1:0]        err_code;

    int n_vec = 0;
    int n_err = 0;

    logic [WR_W-1:0] wr_q[$];
    logic [WR_W-1:0] exp_q[$];
    int done_cnt = 0;
    int restart_cnt = 0;
    int pair_bad = 0;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cpu_halt(cpu_halt), .cpu_restart(cpu_restart), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Observation monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) wr_q.push_back({ram_addr, ram_wdata});
            if (done) done_cnt++;
            if (cpu_restart) restart_cnt++;
            if (done !== cpu_restart) pair_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Compare writes captured since base against exp_q
    task automatic check_writes(input string name, input int base);
        n_vec++;
        if (wr_q.size() - base !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s write_count got %0d expected %0d", name, wr_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (wr_q[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s write%0d got %h expected %h", name, i, wr_q[base + i], exp_q[i]);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ram_addr, ram_wdata, ram_we, cpu_halt, cpu_restart, done, err, err_code} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got addr=%h wdata=%h we=%b halt=%b rst=%b done=%b err=%b code=%0d expected all 0",
                     ram_addr, ram_wdata, ram_we, cpu_halt, cpu_restart, done, err, err_code);
        end
    endtask

    task automatic test_basic_load();
        int base = wr_q.size();
        int d0 = done_cnt;
        int r0 = restart_cnt;
        send_byte(8'hA5, 1'b1);
        n_vec++;
        if (cpu_halt !== 1'b1) begin n_err++; $display("FAIL basic_halt_after_sync got %b expected 1", cpu_halt); end
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        n_vec++;
        if (cpu_halt !== 1'b1) begin n_err++; $display("FAIL basic_halt_mid got %b expected 1", cpu_halt); end
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h42, 1'b1);
`endif
        settle();
        exp_q.push_back({8'd0, 16'h1234});
        exp_q.push_back({8'd1, 16'hABCD});
        check_writes("basic", base);
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done got %0d expected 1", done_cnt - d0); end
        n_vec++;
        if (restart_cnt - r0 !== 1) begin n_err++; $display("FAIL basic_restart got %0d expected 1", restart_cnt - r0); end
        n_vec++;
        if (cpu_halt !== 1'b0) begin n_err++; $display("FAIL basic_halt_after_done got %b expected 0", cpu_halt); end
    endtask

    task automatic test_no_sync();
        int base = wr_q.size();
        send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        settle();
        check_writes("no_sync", base);
        n_vec++;
        if ({cpu_halt, err} !== 2'b00) begin n_err++; $display("FAIL no_sync_state got halt=%b err=%b expected 0 0", cpu_halt, err); end
    endtask

    task automatic test_bad_len();
        int base = wr_q.size();
        int d0;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        settle();
        n_vec++;
        if ({err, err_code, cpu_halt} !== 4'b1101) begin
            n_err++; $display("FAIL len_zero got err=%b code=%0d halt=%b expected 1 2 1", err, err_code, cpu_halt);
        end
        // 257 words exceeds capacity
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h01, 1'b1);
        settle();
        n_vec++;
        if ({err, err_code} !== 3'b110) begin n_err++; $display("FAIL len_257 got err=%b code=%0d expected 1 2", err, err_code); end
        check_writes("bad_len", base);
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        n_vec++;
        if ({err, err_code} !== 3'b000) begin n_err++; $display("FAIL recover_clear got err=%b code=%0d expected 0 0", err, err_code); end
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'hEE, 1'b1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h10, 1'b1);
`endif
        settle();
        exp_q.push_back({8'd0, 16'hFFEE});
        check_writes("recover", base);
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL recover_done got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_frame_err();
        int base = wr_q.size();
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        settle();
        exp_q.push_back({8'd0, 16'h1122});
        check_writes("frame_err", base);
        n_vec++;
        if ({err, err_code, cpu_halt} !== 4'b1011) begin
            n_err++; $display("FAIL frame_err_state got err=%b code=%0d halt=%b expected 1 1 1", err, err_code, cpu_halt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ram_addr, ram_wdata, ram_we, cpu_halt, cpu_restart, done, err, err_code} !== '0) begin
            n_err++;
            $display("FAIL frame_err_reset got addr=%h wdata=%h halt=%b err=%b code=%0d expected all 0",
                     ram_addr, ram_wdata, cpu_halt, err, err_code);
        end
    endtask

    task automatic test_glitch_back_to_back();
        int base = wr_q.size();
        int d0;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_vec++;
        if ({cpu_halt, err} !== 2'b00) begin n_err++; $display("FAIL glitch_state got halt=%b err=%b expected 0 0", cpu_halt, err); end
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'hA5, 1'b1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_byte(8'hA4, 1'b1);
`endif
        settle();
        exp_q.push_back({8'd0, 16'h00A5});
        check_writes("back_to_back", base);
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL back_to_back_done got %0d expected 1", done_cnt - d0); end
    endtask

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base = wr_q.size();
        int d0 = done_cnt;
        int r0 = restart_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h27, 1'b1);
        settle();
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL chk_good_done got %0d expected 1", done_cnt - d0); end
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h26, 1'b1);
        settle();
        exp_q.push_back({8'd0, 16'h1234});
        exp_q.push_back({8'd0, 16'h1234});
        check_writes("checksum", base);
        n_vec++;
        if ({err, err_code} !== 3'b111) begin n_err++; $display("FAIL chk_bad_code got err=%b code=%0d expected 1 3", err, err_code); end
        n_vec++;
        if (restart_cnt - r0 !== 1) begin n_err++; $display("FAIL chk_bad_restart got %0d expected 1 total", restart_cnt - r0); end
        n_vec++;
        if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL chk_bad_done got %0d expected 0", done_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_no_sync();
        test_bad_len();
        test_frame_err();
        test_glitch_back_to_back();
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        n_vec++;
        if (pair_bad !== 0) begin n_err++; $display("FAIL done_restart_pairing got %0d split cycles expected 0", pair_bad); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
